// File: rtl/mem_wb_writeback.sv
// MEM/WB pipeline register and writeback formatter.
// Captures the MEM-stage result fields and drives the register-file write port
// one cycle later. Load data is byte/halfword extracted and sign/zero-extended
// here, and retirements are counted as instructions leave WB.
module mem_wb_writeback #(
   parameter int data_width   = 32,
   parameter int address_bits = 5
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    stall,
   input  logic                    flush,
   input  logic                    mem_valid,
   input  logic                    mem_reg_write,
   input  logic [address_bits-1:0] mem_rd,
   input  logic [1:0]              mem_result_sel,
   input  logic [2:0]              mem_funct3,
   input  logic [data_width-1:0]   mem_alu_result,
   input  logic [data_width-1:0]   mem_load_word,
   input  logic [data_width-1:0]   mem_pc_plus4,
   output logic                    write_enable,
   output logic [address_bits-1:0] write_addr,
   output logic [data_width-1:0]   write_reg_data,
   output logic                    wb_valid,
   output logic [31:0]             retire_count
);

   localparam logic [1:0] SEL_ALU  = 2'b00;
   localparam logic [1:0] SEL_LOAD = 2'b01;
   localparam logic [1:0] SEL_PC4  = 2'b10;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   // WB stage registers
   logic                    vld_p1;
   logic                    reg_write_p1;
   logic [address_bits-1:0] rd_p1;
   logic [1:0]              sel_p1;
   logic [2:0]              funct3_p1;
   logic [data_width-1:0]   alu_p1;
   logic [data_width-1:0]   load_word_p1;
   logic [data_width-1:0]   pc4_p1;
   logic [31:0]             retire_cnt;

   // Extract the addressed byte or halfword of an aligned word and extend it.
   // The halfword lane is picked by off[1] alone; misaligned halves are not
   // split across lanes. Unknown funct3 codes fall back to the whole word.
   function automatic logic [data_width-1:0] format_load(
      input logic [31:0] word,
      input logic [2:0]  f3,
      input logic [1:0]  off
   );
      logic [7:0]         byte_u;
      logic [15:0]        half_u;
      logic signed [7:0]  byte_s;
      logic signed [15:0] half_s;
      logic [data_width-1:0] res;
      case (off)
         2'd0:    byte_u = word[7:0];
         2'd1:    byte_u = word[15:8];
         2'd2:    byte_u = word[23:16];
         default: byte_u = word[31:24];
      endcase
      half_u = off[1] ? word[31:16] : word[15:0];
      byte_s = signed'(byte_u);
      half_s = signed'(half_u);
      case (f3)
         F3_LB:   res = data_width'(byte_s);
         F3_LH:   res = data_width'(half_s);
         F3_LBU:  res = data_width'(byte_u);
         F3_LHU:  res = data_width'(half_u);
         default: res = data_width'(word);
      endcase
      return res;
   endfunction

   // MEM -> WB boundary: flush squashes, stall holds, otherwise capture.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vld_p1       <= 1'b0;
         reg_write_p1 <= 1'b0;
         rd_p1        <= '0;
         sel_p1       <= '0;
         funct3_p1    <= '0;
         alu_p1       <= '0;
         load_word_p1 <= '0;
         pc4_p1       <= '0;
      end else if (flush) begin
         vld_p1 <= 1'b0;
      end else if (!stall) begin
         vld_p1       <= mem_valid;
         reg_write_p1 <= mem_reg_write;
         rd_p1        <= mem_rd;
         sel_p1       <= mem_result_sel;
         funct3_p1    <= mem_funct3;
         alu_p1       <= mem_alu_result;
         load_word_p1 <= mem_load_word;
         pc4_p1       <= mem_pc_plus4;
      end
   end

   // An instruction retires when it leaves WB; a flush of the entering
   // instruction does not stop the one already in WB from retiring.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         retire_cnt <= '0;
      end else if (vld_p1 && !stall) begin
         retire_cnt <= retire_cnt + 32'd1;
      end
   end

   // Writeback data select; sel 11 aliases the ALU path.
   always_comb begin
      write_reg_data = alu_p1;
      case (sel_p1)
         SEL_ALU:  write_reg_data = alu_p1;
         SEL_LOAD: write_reg_data = format_load(load_word_p1[31:0], funct3_p1, alu_p1[1:0]);
         SEL_PC4:  write_reg_data = pc4_p1;
         default:  write_reg_data = alu_p1;
      endcase
   end

   // x0 is hardwired to zero, so writes to it are suppressed here.
   assign write_enable = vld_p1 & reg_write_p1 & (rd_p1 != '0);
   assign write_addr   = rd_p1;
   assign wb_valid     = vld_p1;
   assign retire_count = retire_cnt;

endmodule

// File: tb/tb_mem_wb_writeback.sv
// Testbench for mem_wb_writeback: directed instructions are issued by a driver
// that queues hand-computed write-port results; a monitor pops and compares
// them as each instruction leaves WB.
module tb_mem_wb_writeback;

   typedef struct {
      logic        we;
      logic [4:0]  addr;
      logic [31:0] data;
      string       name;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic        flush;
   logic        mem_valid;
   logic        mem_reg_write;
   logic [4:0]  mem_rd;
   logic [1:0]  mem_result_sel;
   logic [2:0]  mem_funct3;
   logic [31:0] mem_alu_result;
   logic [31:0] mem_load_word;
   logic [31:0] mem_pc_plus4;
   logic        write_enable;
   logic [4:0]  write_addr;
   logic [31:0] write_reg_data;
   logic        wb_valid;
   logic [31:0] retire_count;

   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];

   mem_wb_writeback #(.data_width(32), .address_bits(5)) dut (
      .clk            (clk),
      .reset          (reset),
      .stall          (stall),
      .flush          (flush),
      .mem_valid      (mem_valid),
      .mem_reg_write  (mem_reg_write),
      .mem_rd         (mem_rd),
      .mem_result_sel (mem_result_sel),
      .mem_funct3     (mem_funct3),
      .mem_alu_result (mem_alu_result),
      .mem_load_word  (mem_load_word),
      .mem_pc_plus4   (mem_pc_plus4),
      .write_enable   (write_enable),
      .write_addr     (write_addr),
      .write_reg_data (write_reg_data),
      .wb_valid       (wb_valid),
      .retire_count   (retire_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Drive one MEM-stage instruction for one cycle; queue its result if it
   // will reach WB (valid and not flushed).
   task automatic issue(input string name, input logic v, input logic rw, input logic [4:0] rd,
                        input logic [1:0] sel, input logic [2:0] f3, input logic [31:0] alu,
                        input logic [31:0] ld, input logic [31:0] pc4, input logic [31:0] exp_data,
                        input logic fl);
      exp_t e;
      mem_valid = v; mem_reg_write = rw; mem_rd = rd; mem_result_sel = sel;
      mem_funct3 = f3; mem_alu_result = alu; mem_load_word = ld; mem_pc_plus4 = pc4;
      stall = 1'b0; flush = fl;
      if (v && !fl) begin
         e.we = rw && (rd != 5'd0); e.addr = rd; e.data = exp_data; e.name = name;
         sb.push_back(e);
      end
      @(posedge clk); #1;
      flush = 1'b0;
   endtask

   task automatic bubble();
      issue("bubble", 1'b0, 1'b0, 5'd0, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
   endtask

   // Monitor: the instruction in WB leaves on the next edge when not stalled.
   always @(negedge clk) begin
      if (!reset && wb_valid && !stall) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_wb: got addr %0d data %h, expected no instruction", write_addr, write_reg_data);
         end else begin
            exp_t e;
            e = sb.pop_front();
            if (write_enable !== e.we || write_addr !== e.addr || write_reg_data !== e.data) begin
               errors++;
               $display("FAIL %s: got we=%b addr=%0d data=%h, expected we=%b addr=%0d data=%h",
                        e.name, write_enable, write_addr, write_reg_data, e.we, e.addr, e.data);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got %0d checks, expected completion", checks);
      $fatal(1, "timeout");
   end

   localparam logic [31:0] W = 32'h80F17F22;

   typedef struct {
      logic [2:0]  f3;
      logic [1:0]  off;
      logic [31:0] exp;
   } ld_t;

   ld_t loads[18] = '{
      '{3'b000, 2'd0, 32'h00000022}, '{3'b000, 2'd1, 32'h0000007F},
      '{3'b000, 2'd2, 32'hFFFFFFF1}, '{3'b000, 2'd3, 32'hFFFFFF80},
      '{3'b100, 2'd0, 32'h00000022}, '{3'b100, 2'd1, 32'h0000007F},
      '{3'b100, 2'd2, 32'h000000F1}, '{3'b100, 2'd3, 32'h00000080},
      '{3'b001, 2'd0, 32'h00007F22}, '{3'b001, 2'd1, 32'h00007F22},
      '{3'b001, 2'd2, 32'hFFFF80F1}, '{3'b001, 2'd3, 32'hFFFF80F1},
      '{3'b101, 2'd0, 32'h00007F22}, '{3'b101, 2'd2, 32'h000080F1},
      '{3'b101, 2'd3, 32'h000080F1}, '{3'b010, 2'd0, 32'h80F17F22},
      '{3'b010, 2'd3, 32'h80F17F22}, '{3'b110, 2'd1, 32'h80F17F22}
   };

   initial begin
      // Reset held with a valid writing instruction on the inputs
      reset = 1'b1; stall = 1'b0; flush = 1'b0;
      mem_valid = 1'b1; mem_reg_write = 1'b1; mem_rd = 5'd5; mem_result_sel = 2'b00;
      mem_funct3 = 3'b010; mem_alu_result = 32'hDEAD0005; mem_load_word = 32'h0; mem_pc_plus4 = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_we", {31'd0, write_enable}, 32'd0);
      chk("reset_addr", {27'd0, write_addr}, 32'd0);
      chk("reset_data", write_reg_data, 32'd0);
      chk("reset_valid", {31'd0, wb_valid}, 32'd0);
      chk("reset_count", retire_count, 32'd0);
      reset = 1'b0;
      #1 chk("release_valid", {31'd0, wb_valid}, 32'd0);
      issue("post_reset", 1'b1, 1'b1, 5'd5, 2'b00, 3'b010, 32'hDEAD0005, 32'h0, 32'h0, 32'hDEAD0005, 1'b0);
      chk("capture_1cycle_valid", {31'd0, wb_valid}, 32'd1);

      // ALU results, including the x0 suppression
      issue("alu_rd3", 1'b1, 1'b1, 5'd3, 2'b00, 3'b000, 32'h12345678, 32'h0, 32'h0, 32'h12345678, 1'b0);
      issue("alu_rd0", 1'b1, 1'b1, 5'd0, 2'b00, 3'b000, 32'h12345678, 32'h0, 32'h0, 32'h12345678, 1'b0);
      issue("alu_norw", 1'b1, 1'b0, 5'd8, 2'b00, 3'b000, 32'h0BADF00D, 32'h0, 32'h0, 32'h0BADF00D, 1'b0);

      // Load formatting across types and offsets
      foreach (loads[i])
         issue($sformatf("load_f3_%0d_off%0d", loads[i].f3, loads[i].off), 1'b1, 1'b1, 5'd7, 2'b01,
               loads[i].f3, 32'h00001000 + {30'd0, loads[i].off}, W, 32'h0, loads[i].exp, 1'b0);

      // Link value and the sel=11 alias
      issue("pc4_sel", 1'b1, 1'b1, 5'd1, 2'b10, 3'b000, 32'hAAAA5555, 32'h0, 32'h00000104, 32'h00000104, 1'b0);
      issue("sel11_alu", 1'b1, 1'b1, 5'd1, 2'b11, 3'b000, 32'hAAAA5555, 32'h0, 32'h00000104, 32'hAAAA5555, 1'b0);
      bubble();

      // Asynchronous reset between edges drops the pending write immediately
      issue("pre_async", 1'b1, 1'b1, 5'd9, 2'b00, 3'b000, 32'h00000099, 32'h0, 32'h0, 32'h00000099, 1'b0);
      mem_valid = 1'b0;
      #1 chk("async_pre_we", {31'd0, write_enable}, 32'd1);
      reset = 1'b1;
      #1;
      chk("async_we", {31'd0, write_enable}, 32'd0);
      chk("async_data", write_reg_data, 32'd0);
      chk("async_count", retire_count, 32'd0);
      sb.delete();
      @(posedge clk); #1;
      reset = 1'b0;

      // Stall holds the WB contents and the count
      issue("stall_a", 1'b1, 1'b1, 5'd4, 2'b00, 3'b000, 32'h00000044, 32'h0, 32'h0, 32'h00000044, 1'b0);
      stall = 1'b1;
      mem_valid = 1'b1; mem_rd = 5'd6; mem_alu_result = 32'h00000066;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk($sformatf("stall%0d_we", i), {31'd0, write_enable}, 32'd1);
         chk($sformatf("stall%0d_addr", i), {27'd0, write_addr}, 32'd4);
         chk($sformatf("stall%0d_data", i), write_reg_data, 32'h00000044);
         chk($sformatf("stall%0d_count", i), retire_count, 32'd0);
      end
      issue("stall_b", 1'b1, 1'b1, 5'd6, 2'b00, 3'b000, 32'h00000066, 32'h0, 32'h0, 32'h00000066, 1'b0);
      chk("after_stall_count", retire_count, 32'd1);

      // Flush and stall together: WB empties and the held instruction never retires
      stall = 1'b1; flush = 1'b1;
      mem_valid = 1'b1; mem_rd = 5'd10; mem_alu_result = 32'h000000AA;
      void'(sb.pop_front());
      @(posedge clk); #1;
      flush = 1'b0; stall = 1'b0;
      chk("flush_stall_valid", {31'd0, wb_valid}, 32'd0);
      chk("flush_stall_we", {31'd0, write_enable}, 32'd0);
      chk("flush_stall_count", retire_count, 32'd1);
      bubble();

      // Ten back-to-back instructions with the fifth flushed in MEM
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      for (int i = 0; i < 10; i++)
         issue($sformatf("burst%0d", i), 1'b1, 1'b1, 5'(i + 11), 2'b00, 3'b000,
               32'hC0DE0000 + 32'(i), 32'h0, 32'h0, 32'hC0DE0000 + 32'(i), (i == 4));
      bubble();
      chk("burst_count", retire_count, 32'd9);

      // Counter wrap
      force dut.retire_cnt = 32'hFFFFFFFF;
      #1 release dut.retire_cnt;
      #1 chk("wrap_preload", retire_count, 32'hFFFFFFFF);
      issue("wrap_instr", 1'b1, 1'b1, 5'd2, 2'b00, 3'b000, 32'h00000002, 32'h0, 32'h0, 32'h00000002, 1'b0);
      chk("wrap_hold", retire_count, 32'hFFFFFFFF);
      bubble();
      chk("wrap_zero", retire_count, 32'd0);
      bubble();

      chk("scoreboard_empty", sb.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
